complex_mse_stream: RTL and testbench

COMPLEX_MSE_STREAM -- requirements
Module: complex_mse_stream

---
 rtl/complex_mse_stream.sv | 151 +++++++++++++++
 tb/tb_complex_mse_stream.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/complex_mse_stream.sv
// Streaming complex mean of squared error: mean over 2^L samples of (y - y_hat)^2,
// computed as a complex square (not magnitude), one result per block.

module cmse_lane #(
  parameter int OUT_W = 35,
  parameter int ACC_W = 43,
  parameter int LW    = 4
) (
  input  logic                    i_clk,
  input  logic                    i_arst,
  input  logic signed [OUT_W-1:0] sq,
  input  logic                    load,
  input  logic                    clr,
  input  logic [LW-1:0]           l,
  output logic [OUT_W-1:0]        mean
);
  logic signed [OUT_W-1:0] prod_q;
  logic                    prod_vld;
  logic signed [ACC_W-1:0] acc;

  // mean tracks acc continuously; the FSM picks it up only once acc is final
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      prod_q   <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
      mean     <= '0;
    end else begin
      if (load) prod_q <= sq;
      prod_vld <= load;
      if (clr)           acc <= '0;
      else if (prod_vld) acc <= acc + ACC_W'(prod_q);
      mean <= OUT_W'(acc >>> l);
    end
  end
endmodule

module complex_mse_stream #(
  parameter  int W          = 16,
  parameter  int LOG2_MAX_N = 8,
  localparam int OUT_W      = 2*W+3,
  localparam int ACC_W      = OUT_W+LOG2_MAX_N,
  localparam int LW         = $clog2(LOG2_MAX_N+1)
) (
  input  logic               i_clk,
  input  logic               i_arst,
  input  logic               i_en,
  input  logic               i_cont,
  input  logic               i_stop,
  input  logic [LW-1:0]      i_log2_samples,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [2*W-1:0]     i_y,
  input  logic [2*W-1:0]     i_y_hat,
  output logic               o_valid,
  input  logic               i_rdy,
  output logic [2*OUT_W-1:0] o_data
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  state_t                state;
  logic [LOG2_MAX_N:0]   cnt, n_last;
  logic [LW-1:0]         l_q, l_in;
  logic                  cont_q;
  logic [1:0]            dcnt;
  logic                  fire, start;
  logic signed [W:0]     dr, di;
  logic signed [OUT_W-1:0] drx, dix;
  logic [1:0][OUT_W-1:0] sq, mean;

  // W+1 bit difference cannot wrap; extending to OUT_W keeps the square exact
  assign dr  = (W+1)'($signed(i_y[2*W-1:W])) - (W+1)'($signed(i_y_hat[2*W-1:W]));
  assign di  = (W+1)'($signed(i_y[W-1:0]))   - (W+1)'($signed(i_y_hat[W-1:0]));
  assign drx = OUT_W'(dr);
  assign dix = OUT_W'(di);
  assign sq[1] = drx*drx - dix*dix;
  assign sq[0] = (drx*dix) <<< 1;

  assign l_in   = (i_log2_samples > LW'(LOG2_MAX_N)) ? LW'(LOG2_MAX_N) : i_log2_samples;
  assign n_last = ((LOG2_MAX_N+1)'(1) << l_q) - (LOG2_MAX_N+1)'(1);
  assign fire   = o_ready & i_valid & ~i_stop;
  assign start  = ~i_stop & (((state == IDLE) & i_en) |
                             ((state == OUT) & o_valid & i_rdy & cont_q));

  for (genvar g = 0; g < 2; g++) begin : g_lane
    cmse_lane #(.OUT_W(OUT_W), .ACC_W(ACC_W), .LW(LW)) u_lane (
      .i_clk (i_clk),
      .i_arst(i_arst),
      .sq    (sq[g]),
      .load  (fire),
      .clr   (start),
      .l     (l_q),
      .mean  (mean[g])
    );
  end

  // DRAIN: product flush, final accumulate, shifted mean register, then publish
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state   <= IDLE;
      o_ready <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
      cnt     <= '0;
      l_q     <= '0;
      cont_q  <= 1'b0;
      dcnt    <= '0;
    end else if (i_stop) begin
      state   <= IDLE;
      o_ready <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_en) begin
          state   <= RUN;
          o_ready <= 1'b1;
          cnt     <= '0;
          l_q     <= l_in;
          cont_q  <= i_cont;
        end
        RUN: if (fire) begin
          cnt <= cnt + 1'b1;
          if (cnt == n_last) begin
            state   <= DRAIN;
            o_ready <= 1'b0;
            dcnt    <= '0;
          end
        end
        DRAIN: begin
          dcnt <= dcnt + 1'b1;
          if (dcnt == 2'd2) begin
            o_data  <= mean;
            o_valid <= 1'b1;
            state   <= OUT;
          end
        end
        OUT: if (i_rdy) begin
          o_valid <= 1'b0;
          if (cont_q) begin
            state   <= RUN;
            o_ready <= 1'b1;
            cnt     <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_complex_mse_stream.sv
// Directed bench for complex_mse_stream with hand-computed block means.

module tb_complex_mse_stream;
  localparam int W = 16, LMX = 8, OUT_W = 2*W+3;

  logic               i_clk = 1'b0, i_arst = 1'b1;
  logic               i_en = 1'b0, i_cont = 1'b0, i_stop = 1'b0;
  logic               i_valid = 1'b0, i_rdy = 1'b0;
  logic [3:0]         i_log2_samples = '0;
  logic [2*W-1:0]     i_y = '0, i_y_hat = '0;
  logic               o_ready, o_valid;
  logic [2*OUT_W-1:0] o_data;

  int total = 0, fails = 0;

  complex_mse_stream #(.W(W), .LOG2_MAX_N(LMX)) dut (
    .i_clk(i_clk), .i_arst(i_arst), .i_en(i_en), .i_cont(i_cont), .i_stop(i_stop),
    .i_log2_samples(i_log2_samples), .i_valid(i_valid), .o_ready(o_ready),
    .i_y(i_y), .i_y_hat(i_y_hat), .o_valid(o_valid), .i_rdy(i_rdy), .o_data(o_data)
  );

  always #5 i_clk = ~i_clk;

  function automatic longint re_of();
    return longint'($signed(o_data[2*OUT_W-1:OUT_W]));
  endfunction
  function automatic longint im_of();
    return longint'($signed(o_data[OUT_W-1:0]));
  endfunction

  task automatic chk(input string tag, input longint obs, input longint want);
    total++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic start(input int l, input bit cont);
    i_en = 1'b1; i_cont = cont; i_log2_samples = 4'(l);
    @(negedge i_clk);
    i_en = 1'b0;
  endtask

  // returns at the negedge just after the accepting edge
  task automatic send(input int yr, input int yi, input int hr, input int hi, input int gap);
    bit ok, rdy;
    i_valid = 1'b0;
    repeat (gap) @(negedge i_clk);
    i_y = {16'(yr), 16'(yi)};
    i_y_hat = {16'(hr), 16'(hi)};
    i_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      rdy = o_ready;
      @(negedge i_clk);
      ok = rdy;
    end
    if (!ok) chk("send_timeout", 0, 1);
    i_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input longint re, input longint im);
    int t;
    for (t = 0; t < 100 && !o_valid; t++) @(negedge i_clk);
    chk({tag, "_valid"}, longint'(o_valid), 1);
    chk({tag, "_re"}, re_of(), re);
    chk({tag, "_im"}, im_of(), im);
  endtask

  task automatic take();
    i_valid = 1'b0;
    i_rdy = 1'b1;
    @(negedge i_clk);
    i_rdy = 1'b0;
  endtask

  initial begin
    // reset state and no transfer before i_en
    repeat (2) @(negedge i_clk);
    chk("rst_valid", longint'(o_valid), 0);
    chk("rst_ready", longint'(o_ready), 0);
    chk("rst_data", re_of() | im_of(), 0);
    i_arst = 1'b0;
    i_valid = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("idle_ready", longint'(o_ready), 0);
    i_valid = 1'b0;

    // L=2, d=(2,3): re=-5, im=12, 3-edge latency
    start(2, 1'b0);
    chk("t1_ready", longint'(o_ready), 1);
    repeat (4) send(3, 4, 1, 1, 0);
    chk("t1_ready_off", longint'(o_ready), 0);
    chk("t1_lat0", longint'(o_valid), 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge i_clk);
      chk($sformatf("t1_lat%0d", k), longint'(o_valid), (k == 3) ? 1 : 0);
    end
    wait_out("t1", -5, 12);
    take();
    chk("t1_done_valid", longint'(o_valid), 0);
    chk("t1_done_ready", longint'(o_ready), 0);

    // L=1 floor rounding
    start(1, 1'b0);
    send(0, 1, 0, 0, 0);
    send(0, 0, 0, 0, 0);
    wait_out("t2a", -1, 0);
    take();
    start(1, 1'b0);
    send(1, 0, 0, 0, 0);
    send(0, 0, 0, 0, 0);
    wait_out("t2b", 0, 0);
    take();

    // L=15 clamps to 8; extreme inputs
    start(15, 1'b0);
    for (int n = 0; n < 256; n++) send(-32768, -32768, 32767, 32767, 0);
    chk("t3_ready_off", longint'(o_ready), 0);
    wait_out("t3", 0, 64'sd8589672450);
    take();

    // continuous mode, gaps, L change ignored, back-pressure
    start(2, 1'b1);
    i_log2_samples = 4'd5;
    repeat (4) send(1, 2, 0, 0, $urandom_range(0, 3));
    wait_out("t4a", -3, 4);
    for (int k = 0; k < 5; k++) begin
      i_valid = 1'b1;
      i_y = {16'sd100, 16'sd100};
      chk("t4_hold_valid", longint'(o_valid), 1);
      chk("t4_hold_ready", longint'(o_ready), 0);
      chk("t4_hold_re", re_of(), -3);
      chk("t4_hold_im", im_of(), 4);
      @(negedge i_clk);
    end
    take();
    chk("t4_restart_ready", longint'(o_ready), 1);
    chk("t4_restart_valid", longint'(o_valid), 0);
    send(2, 1, 0, 0, 1);
    send(2, 1, 0, 0, 0);
    send(0, 0, 0, 0, 2);
    send(0, 0, 0, 0, 0);
    wait_out("t4b", 1, 2);
    i_stop = 1'b1;
    @(negedge i_clk);
    i_stop = 1'b0;
    chk("t4_stop_valid", longint'(o_valid), 0);
    chk("t4_stop_ready", longint'(o_ready), 0);
    chk("t4_stop_hold_re", re_of(), 1);

    // stop mid-RUN, then a clean block
    start(2, 1'b0);
    send(100, -200, 0, 0, 0);
    send(100, -200, 0, 0, 0);
    i_stop = 1'b1;
    @(negedge i_clk);
    i_stop = 1'b0;
    chk("t5_stop_ready", longint'(o_ready), 0);
    start(2, 1'b0);
    repeat (4) send(3, 4, 1, 1, 0);
    wait_out("t5", -5, 12);
    take();

    // async reset mid-RUN, then a clean block
    start(2, 1'b0);
    send(100, -200, 0, 0, 0);
    send(100, -200, 0, 0, 0);
    i_arst = 1'b1;
    #1;
    chk("t6_arst_ready", longint'(o_ready), 0);
    chk("t6_arst_valid", longint'(o_valid), 0);
    chk("t6_arst_data", re_of() | im_of(), 0);
    @(negedge i_clk);
    i_arst = 1'b0;
    @(negedge i_clk);
    chk("t6_post_ready", longint'(o_ready), 0);
    start(2, 1'b0);
    repeat (4) send(1, 2, 0, 0, 0);
    wait_out("t6", -3, 4);
    take();

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
